// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: per-channel synchroniser, tick-based debounce,
// press/release strobes and optional auto-repeat, all sharing one tick prescaler.
module btn_debounce_multi #(
   parameter int N_CH         = 4,
   parameter int CLK_HZ       = 100000000,
   parameter int TICK_HZ      = 1000,
   parameter int STABLE_TICKS = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int RPT_DELAY    = 500,
   parameter int RPT_RATE     = 100
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [N_CH-1:0] button,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] pressed,
   output logic [N_CH-1:0] released,
   output logic [N_CH-1:0] autoRepeat,
   output logic            tick
);

   localparam int DIV  = CLK_HZ / TICK_HZ;
   localparam int PW   = $clog2(DIV);
   localparam int SW   = $clog2(STABLE_TICKS + 1);
   localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);
   localparam logic [SW-1:0] SC_LAST   = SW'(STABLE_TICKS - 1);
   localparam logic [RW-1:0] RPT_FIRST = RW'(RPT_DELAY);
   localparam logic [RW-1:0] RPT_NEXT  = RW'(RPT_RATE);
   localparam bit            RPT_ON    = (RPT_DELAY > 0);

   logic [SYNC_STAGES-1:0][N_CH-1:0] sync_r;
   logic [N_CH-1:0]                  syncLvl_s;

   logic [PW-1:0] divCnt_r;
   logic          tickEn_s;
   logic          tick_r;

   logic [N_CH-1:0][SW-1:0] stab_r;
   logic [N_CH-1:0][SW-1:0] stabNxt_s;
   logic [N_CH-1:0][RW-1:0] rpt_r;
   logic [N_CH-1:0][RW-1:0] rptNxt_s;
   logic [N_CH-1:0]         rptArmed_r;
   logic [N_CH-1:0]         rptArmedNxt_s;

   logic [N_CH-1:0] level_r;
   logic [N_CH-1:0] levelNxt_s;
   logic [N_CH-1:0] pressed_r;
   logic [N_CH-1:0] pressNxt_s;
   logic [N_CH-1:0] released_r;
   logic [N_CH-1:0] releaseNxt_s;
   logic [N_CH-1:0] repeat_r;
   logic [N_CH-1:0] repeatNxt_s;

   // Synchroniser chain; stage 0 samples the asynchronous pins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], button};
      end
   end

   assign syncLvl_s = sync_r[SYNC_STAGES-1];

   // Shared prescaler producing one tick_en cycle every DIV clocks.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         divCnt_r <= '0;
         tick_r   <= 1'b0;
      end else begin
         tick_r <= tickEn_s;
         if (tickEn_s) begin
            divCnt_r <= '0;
         end else begin
            divCnt_r <= divCnt_r + PW'(1);
         end
      end
   end

   assign tickEn_s = (divCnt_r == DIV_LAST);

   // Debounce: a level flips only after STABLE_TICKS consecutive differing ticks.
   always_comb begin
      levelNxt_s   = level_r;
      pressNxt_s   = '0;
      releaseNxt_s = '0;
      stabNxt_s    = stab_r;
      for (int i = 0; i < N_CH; i++) begin
         if (!tickEn_s) begin
            stabNxt_s[i] = stab_r[i];
         end else if (syncLvl_s[i] == level_r[i]) begin
            stabNxt_s[i] = '0;
         end else if (stab_r[i] == SC_LAST) begin
            stabNxt_s[i]    = '0;
            levelNxt_s[i]   = ~level_r[i];
            pressNxt_s[i]   = ~level_r[i];
            releaseNxt_s[i] = level_r[i];
         end else begin
            stabNxt_s[i] = stab_r[i] + SW'(1);
         end
      end
   end

   // Auto-repeat: first pulse after RPT_DELAY held ticks, then every RPT_RATE ticks.
   always_comb begin
      rptNxt_s      = rpt_r;
      rptArmedNxt_s = rptArmed_r;
      repeatNxt_s   = '0;
      for (int i = 0; i < N_CH; i++) begin
         // a release accepted this tick wins over a repeat due on the same tick
         if (!RPT_ON || !level_r[i] || releaseNxt_s[i]) begin
            rptNxt_s[i]      = '0;
            rptArmedNxt_s[i] = 1'b0;
         end else if (!tickEn_s) begin
            rptNxt_s[i] = rpt_r[i];
         end else if ((rpt_r[i] + RW'(1)) == (rptArmed_r[i] ? RPT_NEXT : RPT_FIRST)) begin
            rptNxt_s[i]      = '0;
            rptArmedNxt_s[i] = 1'b1;
            repeatNxt_s[i]   = 1'b1;
         end else begin
            rptNxt_s[i] = rpt_r[i] + RW'(1);
         end
      end
   end

   // Per-channel state and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stab_r     <= '0;
         rpt_r      <= '0;
         rptArmed_r <= '0;
         level_r    <= '0;
         pressed_r  <= '0;
         released_r <= '0;
         repeat_r   <= '0;
      end else begin
         stab_r     <= stabNxt_s;
         rpt_r      <= rptNxt_s;
         rptArmed_r <= rptArmedNxt_s;
         level_r    <= levelNxt_s;
         pressed_r  <= pressNxt_s;
         released_r <= releaseNxt_s;
         repeat_r   <= repeatNxt_s;
      end
   end

   assign level      = level_r;
   assign pressed    = pressed_r;
   assign released   = released_r;
   assign autoRepeat = repeat_r;
   assign tick       = tick_r;

endmodule
